debug_dump_sequencer: RTL and testbench



---
 rtl/debug_dump_sequencer.sv | 172 +++++++++++++++++
 tb/tb_debug_dump_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_sequencer.sv
// Streams a post-run debug dump to the host over tx_uart: PC and cycle-count snapshots,
// then every register and every data-memory word, each sent as four bytes, LSB byte first.
module debug_dump_sequencer #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG      = 5,
  parameter int N_REGISTER  = 32,
  parameter int NB_MEM_ADDR = 7,
  parameter int N_MEM_WORDS = 32
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NB_DATA-1:0]     pc_i,
  input  logic [NB_DATA-1:0]     cycle_count_i,
  output logic [NB_REG-1:0]      reg_addr_o,
  input  logic [NB_DATA-1:0]     reg_data_i,
  output logic [NB_MEM_ADDR-1:0] mem_addr_o,
  input  logic [NB_DATA-1:0]     mem_data_i,
  output logic [7:0]             tx_data_o,
  output logic                   tx_start_o,
  input  logic                   tx_done_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam logic [6:0] REG_FIRST = 7'd2;
  localparam logic [6:0] REG_LAST  = 7'(N_REGISTER + 1);
  localparam logic [6:0] MEM_FIRST = 7'(N_REGISTER + 2);
  localparam logic [6:0] LAST_IDX  = 7'(N_REGISTER + N_MEM_WORDS + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_LOAD = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_NEXT = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  state_t                 state_r;
  logic [6:0]             idx_r;
  logic [1:0]             byte_cnt_r;
  logic [NB_DATA-1:0]     pc_snap_r;
  logic [NB_DATA-1:0]     cyc_snap_r;
  logic [NB_DATA-1:0]     shift_r;
  logic [NB_DATA-1:0]     src_s;
  logic [NB_REG-1:0]      reg_addr_r;
  logic [NB_MEM_ADDR-1:0] mem_addr_r;
  logic [7:0]             tx_data_r;
  logic                   tx_start_r;
  logic                   busy_r;
  logic                   done_r;

  function automatic logic [NB_REG-1:0] reg_addr_of(input logic [6:0] idx);
    if ((idx >= REG_FIRST) && (idx <= REG_LAST)) begin
      reg_addr_of = NB_REG'(idx - REG_FIRST);
    end else begin
      reg_addr_of = '0;
    end
  endfunction

  function automatic logic [NB_MEM_ADDR-1:0] mem_addr_of(input logic [6:0] idx);
    if ((idx >= MEM_FIRST) && (idx <= LAST_IDX)) begin
      mem_addr_of = NB_MEM_ADDR'(idx - MEM_FIRST);
    end else begin
      mem_addr_of = '0;
    end
  endfunction

  // Word source for the current index; read data has settled by the LOAD cycle
  always_comb begin
    src_s = mem_data_i;
    if (idx_r == 7'd0) begin
      src_s = pc_snap_r;
    end else if (idx_r == 7'd1) begin
      src_s = cyc_snap_r;
    end else if (idx_r <= REG_LAST) begin
      src_s = reg_data_i;
    end else begin
      src_s = mem_data_i;
    end
  end

  // Dump sequencer with registered read addresses and UART handshake outputs
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r    <= ST_IDLE;
      idx_r      <= 7'd0;
      byte_cnt_r <= 2'd0;
      pc_snap_r  <= '0;
      cyc_snap_r <= '0;
      shift_r    <= '0;
      reg_addr_r <= '0;
      mem_addr_r <= '0;
      tx_data_r  <= 8'd0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      tx_start_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            pc_snap_r  <= pc_i;
            cyc_snap_r <= cycle_count_i;
            idx_r      <= 7'd0;
            reg_addr_r <= reg_addr_of(7'd0);
            mem_addr_r <= mem_addr_of(7'd0);
            busy_r     <= 1'b1;
            state_r    <= ST_ADDR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ADDR: state_r <= ST_LOAD;
        ST_LOAD: begin
          shift_r    <= src_s;
          tx_data_r  <= src_s[7:0];
          tx_start_r <= 1'b1;
          byte_cnt_r <= 2'd0;
          state_r    <= ST_SEND;
        end
        ST_SEND: state_r <= ST_WAIT;
        ST_WAIT: begin
          if (tx_done_i) begin
            if (byte_cnt_r == 2'd3) begin
              state_r <= ST_NEXT;
            end else begin
              shift_r    <= {8'd0, shift_r[NB_DATA-1:8]};
              tx_data_r  <= shift_r[15:8];
              tx_start_r <= 1'b1;
              byte_cnt_r <= byte_cnt_r + 2'd1;
              state_r    <= ST_SEND;
            end
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_NEXT: begin
          if (idx_r == LAST_IDX) begin
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            // Addresses follow the new index so they are valid for the whole ADDR/LOAD pair
            idx_r      <= idx_r + 7'd1;
            reg_addr_r <= reg_addr_of(idx_r + 7'd1);
            mem_addr_r <= mem_addr_of(idx_r + 7'd1);
            state_r    <= ST_ADDR;
          end
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign reg_addr_o = reg_addr_r;
  assign mem_addr_o = mem_addr_r;
  assign tx_data_o  = tx_data_r;
  assign tx_start_o = tx_start_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench: expected byte stream queued at each accepted start, popped per tx_start.
module tb_debug_dump_sequencer;

  localparam int NMW         = 2;
  localparam int TOTAL_BYTES = 4 * (32 + NMW + 2);
  localparam int BUDGET      = 20000;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] pc_i = 32'd0;
  logic [31:0] cycle_count_i = 32'd0;
  logic [4:0]  reg_addr_o;
  logic [31:0] reg_data_i;
  logic [6:0]  mem_addr_o;
  logic [31:0] mem_data_i = 32'd0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i = 1'b0;
  logic        busy_o;
  logic        done_o;

  debug_dump_sequencer #(.N_MEM_WORDS(NMW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .pc_i(pc_i),
    .cycle_count_i(cycle_count_i), .reg_addr_o(reg_addr_o), .reg_data_i(reg_data_i),
    .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i), .tx_data_o(tx_data_o),
    .tx_start_o(tx_start_o), .tx_done_i(tx_done_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  logic [31:0] regs_m [0:31];
  logic [31:0] mem_m  [0:127];
  assign reg_data_i = regs_m[reg_addr_o];
  always @(posedge clock_i) mem_data_i <= mem_m[mem_addr_o];

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  int          rx_count = 0;
  int          start_count = 0;
  int          done_seen = 0;
  bit          spur_mode = 1'b0;
  logic        prev_start = 1'b0;
  logic        prev_done = 1'b0;
  logic [4:0]  prev_reg_addr = 5'd0;
  logic [6:0]  prev_mem_addr = 7'd0;
  logic [7:0]  last_byte = 8'd0;
  int          delay = 0;
  int          dcnt = 0;
  int          widx = 0;
  logic [8:0]  expb = 9'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    push_word(pc);
    push_word(cyc);
    for (int r = 0; r < 32; r++) push_word(regs_m[r]);
    for (int m = 0; m < NMW; m++) push_word(mem_m[m]);
  endtask

  // UART model with scoreboard pop, address and handshake checks
  initial begin
    forever begin
      @(negedge clock_i);
      if (reset_i) begin
        delay = 0; dcnt = 0; tx_done_i = 1'b0;
      end else begin
        if (prev_start) check_val("start_width", 32'(tx_start_o), 32'd0);
        if (!tx_start_o && delay > 0) check_val("data_hold", 32'(tx_data_o), 32'(last_byte));
        if (dcnt > 0) begin
          dcnt--;
          if (dcnt == 0) tx_done_i = 1'b0;
        end
        if (delay > 0) begin
          delay--;
          if (delay == 0) begin
            tx_done_i = 1'b1;
            dcnt = (spur_mode && (rx_count % 4 == 0)) ? 4 : 1;
          end
        end
        if (tx_start_o) begin
          widx = rx_count / 4;
          if (rx_count % 4 == 0) begin
            check_val("reg_addr", 32'(reg_addr_o), (widx >= 2 && widx <= 33) ? 32'(widx - 2) : 32'd0);
            check_val("reg_addr_load", 32'(prev_reg_addr), (widx >= 2 && widx <= 33) ? 32'(widx - 2) : 32'd0);
            check_val("mem_addr", 32'(mem_addr_o), (widx >= 34) ? 32'(widx - 34) : 32'd0);
            check_val("mem_addr_load", 32'(prev_mem_addr), (widx >= 34) ? 32'(widx - 34) : 32'd0);
          end
          expb = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
          check_val("byte", 32'(tx_data_o), 32'(expb));
          last_byte = tx_data_o;
          rx_count++;
          start_count++;
          delay = 12;
        end
      end
      prev_start    = tx_start_o;
      prev_reg_addr = reg_addr_o;
      prev_mem_addr = mem_addr_o;
    end
  end

  // done pulse monitor
  initial begin
    forever begin
      @(negedge clock_i);
      if (prev_done) check_val("done_width", 32'(done_o), 32'd0);
      if (done_o) done_seen++;
      prev_done = done_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
    check_val({tag, "_tx_start"}, 32'(tx_start_o), 32'd0);
    check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_val({tag, "_done"}, 32'(done_o), 32'd0);
    check_val({tag, "_reg_addr"}, 32'(reg_addr_o), 32'd0);
    check_val({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
  endtask

  task automatic start_dump(input logic [31:0] pc, input logic [31:0] cyc);
    @(negedge clock_i);
    rx_count = 0;
    pc_i = pc;
    cycle_count_i = cyc;
    start_i = 1'b1;
    push_dump(pc, cyc);
    @(negedge clock_i);
    start_i = 1'b0;
    check_val("busy_on", 32'(busy_o), 32'd1);
    check_val("start_lat1", 32'(tx_start_o), 32'd0);
    @(negedge clock_i);
    check_val("start_lat2", 32'(tx_start_o), 32'd0);
    @(negedge clock_i);
    check_val("start_lat3", 32'(tx_start_o), 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (rx_count < n && k < BUDGET) begin
      @(negedge clock_i);
      k++;
    end
    check_val("bytes_timeout", 32'(rx_count >= n), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    int d0;
    k = 0;
    d0 = done_seen;
    while (done_seen == d0 && k < BUDGET) begin
      @(negedge clock_i);
      k++;
    end
    check_val("done_timeout", 32'(done_seen), 32'(d0 + 1));
    check_val("byte_count", 32'(rx_count), 32'(TOTAL_BYTES));
    check_val("sb_left", 32'(exp_q.size()), 32'd0);
    @(negedge clock_i);
    check_val("busy_off", 32'(busy_o), 32'd0);
    check_val("done_off", 32'(done_o), 32'd0);
  endtask

  initial begin
    int sc0;
    for (int r = 0; r < 32; r++) regs_m[r] = (32'h01010101 * 32'(r)) ^ 32'hA5000000;
    regs_m[5] = 32'hDEADBEEF;
    for (int m = 0; m < 128; m++) mem_m[m] = 32'h0;
    mem_m[0] = 32'hCAFEF00D;
    mem_m[1] = 32'h12345678;

    reset_i = 1'b1;
    repeat (3) @(negedge clock_i);
    check_reset_outputs("rst");
    reset_i = 1'b0;

    // Full dump with a mid-dump start pulse and changing PC
    start_dump(32'h00000010, 32'h0000002A);
    wait_bytes(20);
    @(negedge clock_i);
    start_i = 1'b1;
    pc_i = 32'hFFFF0000;
    cycle_count_i = 32'h77777777;
    @(negedge clock_i);
    start_i = 1'b0;
    wait_done();

    // Spurious done ticks in NEXT/ADDR/LOAD
    spur_mode = 1'b1;
    start_dump(32'h0BADF00D, 32'h00001234);
    wait_done();
    spur_mode = 1'b0;

    // Reset after 10 bytes truncates the stream
    start_dump(32'h00000400, 32'h00000099);
    wait_bytes(10);
    @(negedge clock_i);
    reset_i = 1'b1;
    exp_q.delete();
    @(negedge clock_i);
    check_reset_outputs("midrst");
    @(negedge clock_i);
    reset_i = 1'b0;
    sc0 = start_count;
    repeat (200) @(negedge clock_i);
    check_val("no_start_after_rst", 32'(start_count - sc0), 32'd0);

    // Fresh dump after reset restarts at the PC word
    start_dump(32'h00000010, 32'h0000002A);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
